// File: rtl/mul_sign_ctrl_if.sv
// rtl/mul_sign_ctrl_if.sv - request, response and multiplier handshake bundle for mul_sign_ctrl
interface mul_sign_ctrl_if;
    logic        valid_i;
    logic        ready_o;
    logic [1:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        flush_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        err_o;
    logic [31:0] mul_a_o;
    logic [31:0] mul_b_o;
    logic        mul_start_o;
    logic [63:0] mul_product_i;
    logic        mul_done_i;

    modport slave (
        input  valid_i, op_i, rs1_i, rs2_i, flush_i, ready_i, mul_product_i, mul_done_i,
        output ready_o, valid_o, result_o, err_o, mul_a_o, mul_b_o, mul_start_o
    );

    modport master (
        output valid_i, op_i, rs1_i, rs2_i, flush_i, ready_i, mul_product_i, mul_done_i,
        input  ready_o, valid_o, result_o, err_o, mul_a_o, mul_b_o, mul_start_o
    );
endinterface

// File: rtl/mul_sign_ctrl.sv
// rtl/mul_sign_ctrl.sv - RISC-V MUL/MULH* sequencer around an unsigned 4-cycle multiplier
module mul_sign_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mul_sign_ctrl_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]  state;
    logic [CW-1:0] cnt;
    logic [1:0]  op_q;
    logic        neg_q;
    logic        a_s_q;
    logic        b_s_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [63:0] raw64;

    logic        c_valid;
    logic [31:0] c_rs1;
    logic [31:0] c_rs2;
    logic        c_a_s;
    logic        c_b_s;
    logic [63:0] c_prod;

    logic        a_s_in;
    logic        b_s_in;
    logic        a_neg_in;
    logic        b_neg_in;
    logic        accept;
    logic        hit;
    logic [63:0] prod64;

    assign bus.ready_o = (state == S_IDLE);
    assign accept      = bus.valid_i && bus.ready_o;

    always_comb begin
        a_s_in   = (bus.op_i == 2'b01) || (bus.op_i == 2'b10);
        b_s_in   = (bus.op_i == 2'b01);
        a_neg_in = a_s_in & bus.rs1_i[31];
        b_neg_in = b_s_in & bus.rs2_i[31];
        // The low word is the same for any signedness, so MUL ignores the sign key
        hit = c_valid && (c_rs1 == bus.rs1_i) && (c_rs2 == bus.rs2_i) &&
              ((bus.op_i == 2'b00) || ((c_a_s == a_s_in) && (c_b_s == b_s_in)));
        prod64 = neg_q ? -raw64 : raw64;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= S_IDLE;
            cnt             <= '0;
            op_q            <= 2'b00;
            neg_q           <= 1'b0;
            a_s_q           <= 1'b0;
            b_s_q           <= 1'b0;
            rs1_q           <= '0;
            rs2_q           <= '0;
            raw64           <= '0;
            c_valid         <= 1'b0;
            c_rs1           <= '0;
            c_rs2           <= '0;
            c_a_s           <= 1'b0;
            c_b_s           <= 1'b0;
            c_prod          <= '0;
            bus.valid_o     <= 1'b0;
            bus.err_o       <= 1'b0;
            bus.result_o    <= '0;
            bus.mul_a_o     <= '0;
            bus.mul_b_o     <= '0;
            bus.mul_start_o <= 1'b0;
        end else if (bus.flush_i) begin
            state           <= S_IDLE;
            bus.mul_start_o <= 1'b0;
            bus.valid_o     <= 1'b0;
            bus.err_o       <= 1'b0;
            if (state == S_RUN) begin
                c_valid <= 1'b0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && hit) begin
                        bus.result_o <= (bus.op_i == 2'b00) ? c_prod[31:0] : c_prod[63:32];
                        bus.valid_o  <= 1'b1;
                        bus.err_o    <= 1'b0;
                        state        <= S_RESP;
                    end else if (accept) begin
                        c_valid         <= 1'b0;
                        op_q            <= bus.op_i;
                        neg_q           <= a_neg_in ^ b_neg_in;
                        a_s_q           <= a_s_in;
                        b_s_q           <= b_s_in;
                        rs1_q           <= bus.rs1_i;
                        rs2_q           <= bus.rs2_i;
                        bus.mul_a_o     <= a_neg_in ? -bus.rs1_i : bus.rs1_i;
                        bus.mul_b_o     <= b_neg_in ? -bus.rs2_i : bus.rs2_i;
                        bus.mul_start_o <= 1'b1;
                        cnt             <= '0;
                        state           <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.mul_done_i) begin
                        raw64           <= bus.mul_product_i;
                        bus.mul_start_o <= 1'b0;
                        state           <= S_FIX;
                    end else if (cnt == CW'(TIMEOUT)) begin
                        bus.mul_start_o <= 1'b0;
                        bus.result_o    <= '0;
                        bus.err_o       <= 1'b1;
                        bus.valid_o     <= 1'b1;
                        state           <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    c_valid      <= 1'b1;
                    c_rs1        <= rs1_q;
                    c_rs2        <= rs2_q;
                    c_a_s        <= a_s_q;
                    c_b_s        <= b_s_q;
                    c_prod       <= prod64;
                    bus.result_o <= (op_q == 2'b00) ? prod64[31:0] : prod64[63:32];
                    bus.err_o    <= 1'b0;
                    bus.valid_o  <= 1'b1;
                    state        <= S_RESP;
                end
                default: begin
                    if (bus.ready_i) begin
                        bus.valid_o <= 1'b0;
                        bus.err_o   <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule
